// File: rtl/pipelined_adder.sv
// pipelined_adder: LATENCY-deep add/subtract pipeline with global stall,
// pass-through tag and a wrapping consumed-result counter.
module pipelined_adder #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2,
  parameter int TAG_W   = 4,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH:0]     sum,
  output logic [TAG_W-1:0]   out_tag,
  output logic [COUNT_W-1:0] out_count
);

  typedef struct packed {
    logic             vld;
    logic [WIDTH:0]   sum;
    logic [TAG_W-1:0] tag;
  } stage_t;

  stage_t             stg_q [LATENCY];
  stage_t             stg_d [LATENCY];
  logic [COUNT_W-1:0] cnt_q;
  logic [COUNT_W-1:0] cnt_d;
  logic [WIDTH:0]     res;
  logic               advance;
  logic               consume;

  assign advance  = !stg_q[LATENCY-1].vld || out_ready;
  assign in_ready = advance;
  assign consume  = stg_q[LATENCY-1].vld && out_ready;

  assign res = op ? ({1'b0, a} - {1'b0, b})
                  : ({1'b0, a} + {1'b0, b});

  // Global stall: either every stage shifts or every stage holds.
  always_comb begin
    stg_d = stg_q;
    if (advance) begin
      stg_d[0].vld = in_valid;
      stg_d[0].sum = res;
      stg_d[0].tag = in_tag;
      for (int i = 1; i < LATENCY; i++) begin
        stg_d[i] = stg_q[i-1];
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (consume) begin
      cnt_d = cnt_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        stg_q[i] <= '0;
      end
      cnt_q <= '0;
    end else begin
      stg_q <= stg_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_valid = stg_q[LATENCY-1].vld;
  assign sum       = stg_q[LATENCY-1].sum;
  assign out_tag   = stg_q[LATENCY-1].tag;
  assign out_count = cnt_q;

endmodule
